// File: rtl/msrv_32_pkg.sv
// Shared definitions for the MS-RV32 multiply/divide unit: M-extension funct3
// encodings, the iteration FSM state type and operand signedness helpers.
package msrv_32_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_MUL    = 3'd0;
    localparam logic [2:0] F3_MULH   = 3'd1;
    localparam logic [2:0] F3_MULHSU = 3'd2;
    localparam logic [2:0] F3_MULHU  = 3'd3;
    localparam logic [2:0] F3_DIV    = 3'd4;
    localparam logic [2:0] F3_DIVU   = 3'd5;
    localparam logic [2:0] F3_REM    = 3'd6;
    localparam logic [2:0] F3_REMU   = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } md_state_t;

    function automatic logic op_a_signed(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    function automatic logic op_b_signed(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

endpackage

// File: rtl/msrv_32_muldiv_iter.sv
// One radix-2 step of the shared datapath. Multiply: acc = {partial product, multiplier}
// shifted right each step. Divide: acc = {partial remainder, dividend/quotient} shifted left.
module msrv_32_muldiv_iter
    import msrv_32_pkg::*;
(
    input  logic                is_div_i,
    input  logic [2*XLEN-1:0]   acc_i,
    input  logic [XLEN-1:0]     operand_i,
    output logic [2*XLEN-1:0]   acc_o
);

    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   div_shift;
    logic [XLEN-1:0] div_rem;
    logic            div_ge;

    always_comb begin
        mul_sum   = {1'b0, acc_i[2*XLEN-1:XLEN]} + (acc_i[0] ? {1'b0, operand_i} : '0);
        div_shift = {acc_i[2*XLEN-1:XLEN], acc_i[XLEN-1]};
        div_ge    = (div_shift >= {1'b0, operand_i});
        // The difference is below the divisor whenever div_ge holds, so 32 bits suffice.
        div_rem   = div_shift[XLEN-1:0] - operand_i;
        acc_o     = '0;
        if (is_div_i) begin
            acc_o = {(div_ge ? div_rem : div_shift[XLEN-1:0]), acc_i[XLEN-2:0], div_ge};
        end else begin
            acc_o = {mul_sum, acc_i[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/msrv_32_muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 32 radix-2 steps on magnitudes, sign fix on
// entry to DONE, and a single-cycle fast path for divide-by-zero and signed overflow.
module msrv_32_muldiv_unit
    import msrv_32_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic              ms_risc32_mp_clk_in,
    input  logic              ms_risc32_mp_rst_in,
    input  logic              start_in,
    input  logic [2:0]        funct3_in,
    input  logic [XLEN-1:0]   rs_1_in,
    input  logic [XLEN-1:0]   rs_2_in,
    input  logic [4:0]        rd_addr_in,
    input  logic              kill_in,
    output logic              busy_out,
    output logic              done_out,
    output logic [XLEN-1:0]   result_out,
    output logic [4:0]        rd_addr_out,
    output logic              wr_en_out,
    output md_state_t         dbg_state_out
);

    md_state_t         state_q, state_d;
    logic [4:0]        cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic              a_neg_q, a_neg_d;
    logic              b_neg_q, b_neg_d;
    logic [XLEN-1:0]   operand_q, operand_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [4:0]        rd_lat_q, rd_lat_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [4:0]        rd_out_q, rd_out_d;

    logic [2*XLEN-1:0] iter_acc;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic              in_a_neg, in_b_neg, in_div_zero, in_div_ovf;
    logic [2*XLEN-1:0] prod_fixed;
    logic [XLEN-1:0]   quo_fixed, rem_fixed, final_result;

    msrv_32_muldiv_iter u_iter (
        .is_div_i  (op_q[2]),
        .acc_i     (acc_q),
        .operand_i (operand_q),
        .acc_o     (iter_acc)
    );

    // Operand conditioning for the accepting edge.
    always_comb begin
        in_a_neg    = op_a_signed(funct3_in) & rs_1_in[XLEN-1];
        in_b_neg    = op_b_signed(funct3_in) & rs_2_in[XLEN-1];
        a_mag       = in_a_neg ? (~rs_1_in + 1'b1) : rs_1_in;
        b_mag       = in_b_neg ? (~rs_2_in + 1'b1) : rs_2_in;
        in_div_zero = funct3_in[2] && (rs_2_in == '0);
        in_div_ovf  = ((funct3_in == F3_DIV) || (funct3_in == F3_REM)) &&
                      (rs_1_in == {1'b1, {(XLEN-1){1'b0}}}) && (rs_2_in == '1);
    end

    // Sign fix applied to the value produced by the last iteration.
    always_comb begin
        prod_fixed   = (a_neg_q ^ b_neg_q) ? (~iter_acc + 1'b1) : iter_acc;
        quo_fixed    = (a_neg_q ^ b_neg_q) ? (~iter_acc[XLEN-1:0] + 1'b1) : iter_acc[XLEN-1:0];
        rem_fixed    = a_neg_q ? (~iter_acc[2*XLEN-1:XLEN] + 1'b1) : iter_acc[2*XLEN-1:XLEN];
        final_result = '0;
        case (op_q)
            F3_MUL:                        final_result = prod_fixed[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU:  final_result = prod_fixed[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:               final_result = quo_fixed;
            default:                       final_result = rem_fixed;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        a_neg_d   = a_neg_q;
        b_neg_d   = b_neg_q;
        operand_d = operand_q;
        acc_d     = acc_q;
        rd_lat_d  = rd_lat_q;
        result_d  = result_q;
        rd_out_d  = rd_out_q;
        case (state_q)
            ST_IDLE: begin
                if (start_in && !kill_in) begin
                    op_d     = funct3_in;
                    a_neg_d  = in_a_neg;
                    b_neg_d  = in_b_neg;
                    rd_lat_d = rd_addr_in;
                    cnt_d    = '0;
                    if (funct3_in[2]) begin
                        operand_d = b_mag;
                        acc_d     = {{XLEN{1'b0}}, a_mag};
                    end else begin
                        operand_d = a_mag;
                        acc_d     = {{XLEN{1'b0}}, b_mag};
                    end
                    // funct3[1] distinguishes REM/REMU from DIV/DIVU.
                    if (in_div_zero) begin
                        state_d  = ST_DONE;
                        result_d = funct3_in[1] ? rs_1_in : '1;
                        rd_out_d = rd_addr_in;
                    end else if (in_div_ovf) begin
                        state_d  = ST_DONE;
                        result_d = funct3_in[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
                        rd_out_d = rd_addr_in;
                    end else begin
                        state_d = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                acc_d = iter_acc;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d  = ST_DONE;
                    result_d = final_result;
                    rd_out_d = rd_lat_q;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (kill_in) begin
            state_d  = ST_IDLE;
            cnt_d    = '0;
            result_d = result_q;
            rd_out_d = rd_out_q;
        end
    end

    always_ff @(posedge ms_risc32_mp_clk_in or posedge ms_risc32_mp_rst_in) begin
        if (ms_risc32_mp_rst_in) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge ms_risc32_mp_clk_in or posedge ms_risc32_mp_rst_in) begin
        if (ms_risc32_mp_rst_in) begin
            cnt_q     <= '0;
            op_q      <= '0;
            a_neg_q   <= 1'b0;
            b_neg_q   <= 1'b0;
            operand_q <= '0;
            acc_q     <= '0;
            rd_lat_q  <= '0;
            result_q  <= '0;
            rd_out_q  <= '0;
        end else begin
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            a_neg_q   <= a_neg_d;
            b_neg_q   <= b_neg_d;
            operand_q <= operand_d;
            acc_q     <= acc_d;
            rd_lat_q  <= rd_lat_d;
            result_q  <= result_d;
            rd_out_q  <= rd_out_d;
        end
    end

    assign busy_out      = (state_q != ST_IDLE);
    assign done_out      = (state_q == ST_DONE);
    assign wr_en_out     = done_out;
    assign result_out    = result_q;
    assign rd_addr_out   = rd_out_q;
    assign dbg_state_out = state_q;

endmodule
